// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared move codes, debounce state type and code resolution
package pong_pkg;

    // Move codes shared with the paddle position register.
    localparam logic [1:0] BTN_NONE = 2'd0;
    localparam logic [1:0] BTN_INC  = 2'd1;
    localparam logic [1:0] BTN_DEC  = 2'd2;

    // S0: stable 0, W1: waiting to go 1, S1: stable 1, W0: waiting to go 0.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        W1 = 2'd1,
        S1 = 2'd2,
        W0 = 2'd3
    } deb_state_t;

    // Debounced levels {dec, inc} to move code; both pressed cancels out.
    function automatic logic [1:0] resolve_move(input logic [1:0] levels);
        logic [1:0] code;
        case (levels)
            2'b01:   code = BTN_INC;
            2'b10:   code = BTN_DEC;
            default: code = BTN_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one-bit synchronizer plus counting debounce FSM
module btn_debounce
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    // A single-cycle debounce accepts a change on the first differing cycle.
    localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);

    logic                 sync1_q;
    logic                 sync2_q;
    deb_state_t           state_q;
    deb_state_t           state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Next state: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S0: begin
                cnt_d = '0;
                if (sync2_q) begin
                    if (DIRECT) begin
                        state_d = S1;
                    end else begin
                        state_d = W1;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            W1: begin
                if (!sync2_q) begin
                    state_d = S0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S1: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    if (DIRECT) begin
                        state_d = S0;
                    end else begin
                        state_d = W0;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            W0: begin
                if (sync2_q) begin
                    state_d = S1;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S0;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and debounce counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The accepted level is 1 while stable high or while waiting to fall.
    assign stable = (state_q == S1) || (state_q == W0);

endmodule

// File: rtl/paddle_btn_cond.sv
// rtl/paddle_btn_cond.sv - per-player button conditioner feeding the paddle move code
module paddle_btn_cond
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn,
    output logic [1:0] btn_stable
);

    logic [1:0] code;
    logic [1:0] btn_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_deb_inc (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw[0]),
        .stable(btn_stable[0])
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_deb_dec (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw[1]),
        .stable(btn_stable[1])
    );

    assign code = resolve_move(btn_stable);

    // One move per frame: the code is presented only on the cycle after a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= BTN_NONE;
        end else begin
            btn_q <= frame_tick ? code : BTN_NONE;
        end
    end

    assign btn = btn_q;

endmodule
